// File: rtl/regfile_wr_arb_pkg.sv
// rtl/regfile_wr_arb_pkg.sv - shared defines for the register-file write arbiter
//
// Holds the register-address width, data width, write-enable and reset levels,
// the zero constants and the arbiter state encodings.
package regfile_wr_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 3;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  localparam logic [DATA_W-1:0]     ZERO_WORD = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// rtl/regfile_wr_arb.sv - two-requester register-file write-port arbiter
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   p_valid/p_waddr/p_wdata   pipeline writeback request, p_ready accepts it
//   m_valid/m_waddr/m_wdata   multi-cycle unit request, m_ready accepts it
//   stall_req                 freezes the pipeline writeback stage while m is forced
//   we/waddr/wdata/wsrc       registered register-file write port (wsrc 1 = m)
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_valid,
  input  logic [REG_ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0]     p_wdata,
  output logic                  p_ready,
  input  logic                  m_valid,
  input  logic [REG_ADDR_W-1:0] m_waddr,
  input  logic [DATA_W-1:0]     m_wdata,
  output logic                  m_ready,
  output logic                  stall_req,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wsrc
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("regfile_wr_arb: STARVE_LIMIT must be within 1..7");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  wsrc_q, wsrc_d;

  logic p_hs;
  logic m_hs;
  logic m_wait;

  assign p_hs   = p_valid & p_ready;
  assign m_hs   = m_valid & m_ready;
  assign m_wait = m_valid & ~m_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        // Refusing m once more would exceed the starvation budget.
        if (m_wait && (cnt_q == CNT_LAST)) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        // m_ready follows m_valid here, so FORCE always lasts one cycle:
        // either m is accepted or it has withdrawn.
        state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Output logic; every grant is masked while reset is asserted so no
  // request is consumed during reset.
  always_comb begin
    p_ready   = 1'b0;
    m_ready   = 1'b0;
    stall_req = 1'b0;
    if (rst != RST_ENABLE) begin
      case (state_q)
        ST_NORMAL: begin
          p_ready = p_valid;
          m_ready = m_valid & ~p_valid;
        end
        ST_FORCE: begin
          m_ready   = m_valid;
          stall_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of consecutive cycles m has been refused.
  always_comb begin
    cnt_d = cnt_q;
    if (!m_valid || m_hs) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Write port: the winner's request is presented one cycle after its
  // handshake. Address 0 is consumed but never written.
  always_comb begin
    we_d    = WRITE_DISABLE;
    waddr_d = ZERO_ADDR;
    wdata_d = ZERO_WORD;
    wsrc_d  = 1'b0;
    if (p_hs) begin
      we_d    = (p_waddr != ZERO_ADDR) ? WRITE_ENABLE : WRITE_DISABLE;
      waddr_d = p_waddr;
      wdata_d = p_wdata;
      wsrc_d  = 1'b0;
    end else if (m_hs) begin
      we_d    = (m_waddr != ZERO_ADDR) ? WRITE_ENABLE : WRITE_DISABLE;
      waddr_d = m_waddr;
      wdata_d = m_wdata;
      wsrc_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q   <= '0;
      we_q    <= WRITE_DISABLE;
      waddr_q <= ZERO_ADDR;
      wdata_q <= ZERO_WORD;
      wsrc_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wsrc_q  <= wsrc_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wsrc  = wsrc_q;

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive cycles the multi-cycle requester may be refused before it is forced through; legal range 1..7.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port p_valid  input  1  pipeline writeback request.
REQ-005 SHALL have port p_waddr  input  5  pipeline destination register.
REQ-006 SHALL have port p_wdata  input  32  pipeline write data.
REQ-007 SHALL have port p_ready  output  1  pipeline request accepted this cycle.
REQ-008 SHALL have port m_valid  input  1  multi-cycle unit (div/load) write request.
REQ-009 SHALL have port m_waddr  input  5  multi-cycle destination register.
REQ-010 SHALL have port m_wdata  input  32  multi-cycle write data.
REQ-011 SHALL have port m_ready  output  1  multi-cycle request accepted this cycle.
REQ-012 SHALL have port stall_req  output  1  asks the pipeline to freeze its writeback stage; high in FORCE.
REQ-013 SHALL have port we  output  1  register-file write enable, registered.
REQ-014 SHALL have port waddr  output  5  register-file write address, registered.
REQ-015 SHALL have port wdata  output  32  register-file write data, registered.
REQ-016 SHALL have port wsrc  output  1  source of the current write: 0 = pipeline, 1 = multi-cycle; registered.

Function
REQ-017 SHALL accept a request on a handshake (valid && ready), with p_ready and m_ready never both high.
REQ-018 SHALL, in state NORMAL, grant the pipeline whenever p_valid=1, and otherwise grant the multi-cycle unit when m_valid=1.
REQ-019 SHALL, in state FORCE, hold p_ready=0 and m_ready=m_valid, and drive stall_req=1.
REQ-020 SHALL keep a saturating wait counter that increments each cycle m_valid=1 && m_ready=0, and clears on an m handshake or when m_valid=0.
REQ-021 SHALL move NORMAL->FORCE when the counter equals STARVE_LIMIT-1 and m is refused that cycle, so that m is granted exactly STARVE_LIMIT cycles after it first waits.
REQ-022 SHALL move FORCE->NORMAL after one m handshake, or immediately when m_valid=0 in FORCE.
REQ-023 SHALL present the accepted request one cycle after its handshake: we=1, waddr/wdata from the winner, wsrc set.
REQ-024 SHALL drive we=0 for an accepted request whose address is 0; the request is still consumed.
REQ-025 SHALL drive we=0, waddr=0, wdata=0 and wsrc=0 in any cycle following no handshake.
REQ-026 SHALL treat requester data as sampled only on the handshake cycle; requesters hold valid/addr/data until accepted.
REQ-027 SHALL keep same-cycle requests to the same register in grant order, with no merging; issue logic owns WAW ordering.

Reset
REQ-028 SHALL, while rst=1, force we=0, waddr=0, wdata=0, wsrc=0, p_ready=0, m_ready=0, stall_req=0, counter=0 and state=NORMAL.
REQ-029 SHALL discard a request accepted in the cycle rst rises (we=0 in the following cycle).
REQ-030 SHALL accept requests starting in the first cycle with rst=0.

Structure
REQ-031 SHALL take the register-address width, data width, WriteEnable/RstEnable levels and ZeroWord constant from the shared defines file, and SHALL define NORMAL/FORCE state encodings there.
REQ-032 SHALL be a single module with no sub-modules; the counter and FSM are local.

Verification
REQ-033 SHALL cover this scenario: p only, addr 5 data 0x1234 at cycle 0 -> p_ready=1 in cycle 0; we=1, waddr=5, wdata=0x1234, wsrc=0 in cycle 1.
REQ-034 SHALL cover this scenario: p and m valid continuously, STARVE_LIMIT=3 -> p granted in cycles 0-2; cycle 3 is FORCE with stall_req=1 and m_ready=1; wsrc=1 in cycle 4; NORMAL in cycle 4.
REQ-035 SHALL cover this scenario: m only, addr 0 data 0xFFFFFFFF -> m_ready=1 in cycle 0; we=0 in cycle 1.
REQ-036 SHALL cover this scenario: m waits 2 cycles, then p_valid drops -> m granted in cycle 2 through NORMAL; counter back at 0; no FORCE.
REQ-037 SHALL cover this scenario: rst=1 in the same cycle as a p handshake on addr 7 -> we=0 in the next cycle; all outputs 0; NORMAL restored.
REQ-038 SHALL cover this scenario: m_valid drops while in FORCE -> NORMAL in the next cycle with stall_req=0.
